// File: rtl/cache_def.sv
// Shared types and constants for the direct-mapped cache controller and its storage.
// A line is 128 bits: tag = addr[31:14], index = addr[13:4], word = addr[3:2].
package cache_def;

    localparam int TAGMSB   = 31;
    localparam int TAGLSB   = 14;
    localparam int INDEX_W  = 10;
    localparam int OFFSET_W = 4;
    localparam int TAG_W    = TAGMSB - TAGLSB + 1;
    localparam int LINE_W   = 128;
    localparam int BEAT_W   = 32;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WRITE_BACK,
        ALLOCATE
    } cache_state_type;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
    } cache_tag_type;

    typedef struct packed {
        logic [INDEX_W-1:0] index;
        logic               we;
    } cache_req_type;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rw;
        logic        valid;
    } cpu_req_type;

    typedef struct packed {
        logic [31:0] data;
        logic        ready;
    } cpu_result_type;

    typedef struct packed {
        logic [31:0]       addr;
        logic [LINE_W-1:0] data;
        logic              rw;
        logic              valid;
    } mem_req_type;

    typedef struct packed {
        logic [31:0] data;
        logic        ready;
    } mem_data_type;

    function automatic logic [31:0] line_addr(input logic [TAG_W-1:0]   tag,
                                              input logic [INDEX_W-1:0] index);
        return {tag, index, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dm_cache_store.sv
// Tag and data arrays: combinational read by index, one synchronous write port.
// Valid/dirty live in flops so a reset invalidates every line at once.
module dm_cache_store
    import cache_def::*;
#(
    parameter int NUM_LINES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  cache_req_type     req,
    input  cache_tag_type     tag_wr,
    input  logic [LINE_W-1:0] data_wr,
    output cache_tag_type     tag_rd,
    output logic [LINE_W-1:0] data_rd
);

    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [LINE_W-1:0]    data_mem [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;

    always_ff @(posedge clk) begin
        if (req.we) begin
            tag_mem[req.index]  <= tag_wr.tag;
            data_mem[req.index] <= data_wr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (req.we) begin
            valid_q[req.index] <= tag_wr.valid;
            dirty_q[req.index] <= tag_wr.dirty;
        end
    end

    assign tag_rd = '{valid: valid_q[req.index],
                      dirty: dirty_q[req.index],
                      tag:   tag_mem[req.index]};
    assign data_rd = data_mem[req.index];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-back, write-allocate cache controller between a CPU port and a 128-bit memory port.
// Define CACHE_STATS_EN to add the hit_cnt/miss_cnt per-request counters.
module dm_cache_ctrl
    import cache_def::*;
#(
    parameter int NUM_LINES = 1024,
    parameter int BEATS     = 4
) (
    input  logic           clk,
    input  logic           rst,
`ifdef CACHE_STATS_EN
    output logic [31:0]    hit_cnt,
    output logic [31:0]    miss_cnt,
`endif
    input  cpu_req_type    cpu_req,
    output cpu_result_type cpu_res,
    output mem_req_type    mem_req,
    input  mem_data_type   mem_data
);

    localparam int             BCW       = $clog2(BEATS);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

    cache_state_type   state_q, state_d;
    cpu_req_type       req_q, req_d;
    cpu_result_type    res_q, res_d;
    mem_req_type       mreq_q, mreq_d;
    logic [BCW-1:0]    beat_q, beat_d;
    logic [LINE_W-1:0] line_q, line_d;

    cache_req_type     st_req;
    cache_tag_type     tag_wr;
    cache_tag_type     tag_rd;
    logic [LINE_W-1:0] data_wr;
    logic [LINE_W-1:0] data_rd;

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;
    logic [1:0]         req_word;
    logic               hit;
    logic               unused_req_bits;

    assign req_tag         = req_q.addr[TAGMSB:TAGLSB];
    assign req_index       = req_q.addr[TAGLSB-1:OFFSET_W];
    assign req_word        = req_q.addr[OFFSET_W-1:2];
    assign hit             = tag_rd.valid && (tag_rd.tag == req_tag);
    assign unused_req_bits = ^{req_q.addr[1:0], req_q.valid};

    dm_cache_store #(
        .NUM_LINES(NUM_LINES)
    ) u_store (
        .clk    (clk),
        .rst    (rst),
        .req    (st_req),
        .tag_wr (tag_wr),
        .data_wr(data_wr),
        .tag_rd (tag_rd),
        .data_rd(data_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= '0;
            res_q   <= '0;
            mreq_q  <= '0;
            beat_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            res_q   <= res_d;
            mreq_q  <= mreq_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        res_d   = '{data: res_q.data, ready: 1'b0};
        mreq_d  = mreq_q;
        beat_d  = beat_q;
        line_d  = line_q;
        st_req  = '{index: req_index, we: 1'b0};
        tag_wr  = '{valid: 1'b1, dirty: 1'b0, tag: req_tag};
        data_wr = line_q;

        case (state_q)
            IDLE: begin
                // The ready cycle also blocks acceptance, so a held valid is not re-taken.
                if (cpu_req.valid && !res_q.ready) begin
                    req_d   = cpu_req;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    if (req_q.rw) begin
                        data_wr                             = data_rd;
                        data_wr[BEAT_W*req_word +: BEAT_W]  = req_q.data;
                        tag_wr.dirty                        = 1'b1;
                        st_req.we                           = 1'b1;
                    end else begin
                        res_d.data = data_rd[BEAT_W*req_word +: BEAT_W];
                    end
                    res_d.ready = 1'b1;
                    state_d     = IDLE;
                end else if (tag_rd.valid && tag_rd.dirty) begin
                    mreq_d  = '{addr:  line_addr(tag_rd.tag, req_index),
                                data:  data_rd,
                                rw:    1'b1,
                                valid: 1'b1};
                    state_d = WRITE_BACK;
                end else begin
                    mreq_d  = '{addr:  line_addr(req_tag, req_index),
                                data:  mreq_q.data,
                                rw:    1'b0,
                                valid: 1'b1};
                    state_d = ALLOCATE;
                end
            end
            WRITE_BACK: begin
                if (mem_data.ready) begin
                    mreq_d.addr = line_addr(req_tag, req_index);
                    mreq_d.rw   = 1'b0;
                    state_d     = ALLOCATE;
                end
            end
            ALLOCATE: begin
                if (mem_data.ready) begin
                    line_d[BEAT_W*beat_q +: BEAT_W] = mem_data.data;
                    beat_d                          = beat_q + 1'b1;
                    // Nothing reaches the arrays until the last beat, so an abort leaves no partial line.
                    if (beat_q == LAST_BEAT) begin
                        data_wr      = line_d;
                        st_req.we    = 1'b1;
                        beat_d       = '0;
                        mreq_d.valid = 1'b0;
                        state_d      = COMPARE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cpu_res = res_q;
    assign mem_req = mreq_q;

`ifdef CACHE_STATS_EN
    // Only a compare entered straight from IDLE is a new request; the post-refill one is not.
    logic first_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            first_q  <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            first_q <= (state_q == IDLE);
            if (state_q == COMPARE && first_q) begin
                if (hit) begin
                    hit_cnt <= hit_cnt + 32'd1;
                end else begin
                    miss_cnt <= miss_cnt + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl: cold refill, hits, dirty write-back, memory stall, reset abort.
module tb_dm_cache_ctrl;
    import cache_def::*;

    logic           clk = 1'b0;
    logic           rst;
    cpu_req_type    cpu_req;
    cpu_result_type cpu_res;
    mem_req_type    mem_req;
    mem_data_type   mem_data;
`ifdef CACHE_STATS_EN
    logic [31:0]    hit_cnt;
    logic [31:0]    miss_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0]  beats [4];
    bit           mem_en;
    int           bi, rd_cnt, wb_cnt, vcnt;
    logic [31:0]  rd_addr, wb_addr;
    logic [127:0] wb_data;

    dm_cache_ctrl dut (
        .clk     (clk),
        .rst     (rst),
`ifdef CACHE_STATS_EN
        .hit_cnt (hit_cnt),
        .miss_cnt(miss_cnt),
`endif
        .cpu_req (cpu_req),
        .cpu_res (cpu_res),
        .mem_req (mem_req),
        .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_setup(input logic [31:0] b0, b1, b2, b3);
        beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
        bi = 0; rd_cnt = 0; wb_cnt = 0; vcnt = 0;
        rd_addr = '0; wb_addr = '0; wb_data = '0;
        mem_en = 1'b1;
    endtask

    // Memory answers every request immediately when enabled; records what it saw.
    task automatic serve();
        mem_data = '0;
        if (mem_req.valid) vcnt++;
        if (mem_en && mem_req.valid) begin
            mem_data.ready = 1'b1;
            if (mem_req.rw) begin
                wb_cnt++;
                wb_addr = mem_req.addr;
                wb_data = mem_req.data;
            end else begin
                if (bi == 0) begin
                    rd_cnt++;
                    rd_addr = mem_req.addr;
                end
                mem_data.data = beats[bi];
                bi = (bi + 1) % 4;
            end
        end
    endtask

    // lat = cycles from the sampling edge of valid to the first visible ready (-1 on timeout).
    task automatic run_req(input logic [31:0] a, input logic [31:0] d, input logic rw,
                           output int lat, output logic [31:0] rdata, output int np);
        lat = -1; rdata = '0; np = 0;
        cpu_req = '{addr: a, data: d, rw: rw, valid: 1'b1};
        for (int c = 1; c <= 40; c++) begin
            serve();
            step();
            cpu_req.valid = 1'b0;
            if (cpu_res.ready) begin
                np++;
                if (lat < 0) begin
                    lat   = c;
                    rdata = cpu_res.data;
                end
            end
            if (lat >= 0 && c >= lat + 3) break;
        end
        mem_data = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cpu_req = '{addr: 32'h1230, data: 32'h5555_AAAA, rw: 1'b1, valid: 1'b1};
        mem_data = '{data: 32'hFFFF_FFFF, ready: 1'b1};
        repeat (3) step();
        total++; if (cpu_res.ready !== 1'b0) begin bad++; $display("FAIL rst_res_ready got=%b want=0", cpu_res.ready); end
        total++; if (cpu_res.data !== 32'h0) begin bad++; $display("FAIL rst_res_data got=%h want=0", cpu_res.data); end
        total++; if (mem_req.valid !== 1'b0) begin bad++; $display("FAIL rst_mem_valid got=%b want=0", mem_req.valid); end
        total++; if (mem_req.rw !== 1'b0) begin bad++; $display("FAIL rst_mem_rw got=%b want=0", mem_req.rw); end
        total++; if (mem_req.addr !== 32'h0) begin bad++; $display("FAIL rst_mem_addr got=%h want=0", mem_req.addr); end
        total++; if (mem_req.data !== 128'h0) begin bad++; $display("FAIL rst_mem_data got=%h want=0", mem_req.data); end
        cpu_req = '0;
        mem_data = '0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_cold_read();
        int lat, np;
        logic [31:0] rd;
        mem_setup(32'hA0, 32'hA1, 32'hA2, 32'hA3);
        run_req(32'h0000_1230, 32'h0, 1'b0, lat, rd, np);
        total++; if (lat !== 7) begin bad++; $display("FAIL cold_latency got=%0d want=7", lat); end
        total++; if (rd !== 32'hA0) begin bad++; $display("FAIL cold_data got=%h want=000000a0", rd); end
        total++; if (np !== 1) begin bad++; $display("FAIL cold_ready_pulses got=%0d want=1", np); end
        total++; if (rd_cnt !== 1) begin bad++; $display("FAIL cold_mem_reads got=%0d want=1", rd_cnt); end
        total++; if (rd_addr !== 32'h0000_1230) begin bad++; $display("FAIL cold_mem_addr got=%h want=00001230", rd_addr); end
        total++; if (wb_cnt !== 0) begin bad++; $display("FAIL cold_writebacks got=%0d want=0", wb_cnt); end
    endtask

    task automatic test_hit();
        int lat, np;
        logic [31:0] rd;
        mem_setup(32'h0, 32'h0, 32'h0, 32'h0);
        run_req(32'h0000_1230, 32'h0, 1'b0, lat, rd, np);
        total++; if (lat !== 2) begin bad++; $display("FAIL hit_latency got=%0d want=2", lat); end
        total++; if (rd !== 32'hA0) begin bad++; $display("FAIL hit_data_w0 got=%h want=000000a0", rd); end
        total++; if (vcnt !== 0) begin bad++; $display("FAIL hit_mem_valid_cycles got=%0d want=0", vcnt); end
        run_req(32'h0000_123C, 32'h0, 1'b0, lat, rd, np);
        total++; if (rd !== 32'hA3) begin bad++; $display("FAIL hit_data_w3 got=%h want=000000a3", rd); end
        total++; if (np !== 1) begin bad++; $display("FAIL hit_ready_pulses got=%0d want=1", np); end
    endtask

    task automatic test_write_back();
        int lat, np;
        logic [31:0] rd;
        mem_setup(32'h0, 32'h0, 32'h0, 32'h0);
        run_req(32'h0000_1234, 32'hDEAD_BEEF, 1'b1, lat, rd, np);
        total++; if (lat !== 2) begin bad++; $display("FAIL wr_hit_latency got=%0d want=2", lat); end
        total++; if (vcnt !== 0) begin bad++; $display("FAIL wr_hit_mem_valid_cycles got=%0d want=0", vcnt); end
        mem_setup(32'hB0, 32'hB1, 32'hB2, 32'hB3);
        run_req(32'h0000_5234, 32'h0, 1'b0, lat, rd, np);
        total++; if (wb_cnt !== 1) begin bad++; $display("FAIL wb_count got=%0d want=1", wb_cnt); end
        total++; if (wb_addr !== 32'h0000_1230) begin bad++; $display("FAIL wb_addr got=%h want=00001230", wb_addr); end
        total++; if (wb_data[63:32] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wb_word1 got=%h want=deadbeef", wb_data[63:32]); end
        total++; if (wb_data !== {32'hA3, 32'hA2, 32'hDEAD_BEEF, 32'hA0}) begin bad++; $display("FAIL wb_line got=%h", wb_data); end
        total++; if (rd_addr !== 32'h0000_5230) begin bad++; $display("FAIL wb_refill_addr got=%h want=00005230", rd_addr); end
        total++; if (rd !== 32'hB1) begin bad++; $display("FAIL wb_read_data got=%h want=000000b1", rd); end
        total++; if (lat !== 8) begin bad++; $display("FAIL wb_latency got=%0d want=8", lat); end
    endtask

    task automatic test_stall();
        int lat, np, moved, rdy;
        logic [31:0] rd;
        mem_req_type snap;
        mem_setup(32'hD0, 32'hD1, 32'hD2, 32'hD3);
        mem_en = 1'b0;
        mem_data = '0;
        cpu_req = '{addr: 32'h0000_9008, data: 32'h1234_5678, rw: 1'b1, valid: 1'b1};
        step();
        cpu_req.valid = 1'b0;
        step();
        snap = mem_req;
        total++; if (snap.valid !== 1'b1) begin bad++; $display("FAIL stall_req_valid got=%b want=1", snap.valid); end
        total++; if (snap.rw !== 1'b0) begin bad++; $display("FAIL stall_req_rw got=%b want=0", snap.rw); end
        total++; if (snap.addr !== 32'h0000_9000) begin bad++; $display("FAIL stall_req_addr got=%h want=00009000", snap.addr); end
        moved = 0; rdy = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (mem_req !== snap) moved++;
            if (cpu_res.ready !== 1'b0) rdy++;
        end
        total++; if (moved !== 0) begin bad++; $display("FAIL stall_req_stable changed_cycles=%0d want=0", moved); end
        total++; if (rdy !== 0) begin bad++; $display("FAIL stall_cpu_ready ready_cycles=%0d want=0", rdy); end
        mem_en = 1'b1;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            serve();
            step();
            if (cpu_res.ready === 1'b1) begin
                lat = c;
                break;
            end
        end
        mem_data = '0;
        repeat (2) step();
        total++; if (lat !== 5) begin bad++; $display("FAIL stall_resume_latency got=%0d want=5", lat); end
        total++; if (rd_cnt !== 1) begin bad++; $display("FAIL stall_mem_reads got=%0d want=1", rd_cnt); end
        run_req(32'h0000_9008, 32'h0, 1'b0, lat, rd, np);
        total++; if (rd !== 32'h1234_5678) begin bad++; $display("FAIL stall_write_data got=%h want=12345678", rd); end
        total++; if (lat !== 2) begin bad++; $display("FAIL stall_rehit_latency got=%0d want=2", lat); end
        run_req(32'h0000_9004, 32'h0, 1'b0, lat, rd, np);
        total++; if (rd !== 32'hD1) begin bad++; $display("FAIL stall_refill_word1 got=%h want=000000d1", rd); end
    endtask

`ifdef CACHE_STATS_EN
    task automatic test_stats();
        total++; if (hit_cnt !== 32'd5) begin bad++; $display("FAIL stats_hits got=%0d want=5", hit_cnt); end
        total++; if (miss_cnt !== 32'd3) begin bad++; $display("FAIL stats_misses got=%0d want=3", miss_cnt); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (hit_cnt !== 32'd0) begin bad++; $display("FAIL stats_hits_rst got=%0d want=0", hit_cnt); end
        total++; if (miss_cnt !== 32'd0) begin bad++; $display("FAIL stats_misses_rst got=%0d want=0", miss_cnt); end
    endtask
`endif

    task automatic test_reset_mid();
        int lat, np, rdy;
        logic [31:0] rd;
        logic pre_vld;
        mem_setup(32'hC0, 32'hC1, 32'hC2, 32'hC3);
        cpu_req = '{addr: 32'h0000_2000, data: 32'h0, rw: 1'b0, valid: 1'b1};
        step();
        cpu_req.valid = 1'b0;
        step();
        repeat (3) begin
            serve();
            step();
        end
        pre_vld = mem_req.valid;
        mem_data = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (pre_vld !== 1'b1) begin bad++; $display("FAIL abort_pre_valid got=%b want=1", pre_vld); end
        total++; if (mem_req.valid !== 1'b0) begin bad++; $display("FAIL abort_mem_valid got=%b want=0", mem_req.valid); end
        rdy = 0;
        for (int c = 0; c < 6; c++) begin
            if (cpu_res.ready !== 1'b0) rdy++;
            step();
        end
        total++; if (rdy !== 0) begin bad++; $display("FAIL abort_cpu_ready ready_cycles=%0d want=0", rdy); end
        mem_setup(32'hE0, 32'hE1, 32'hE2, 32'hE3);
        run_req(32'h0000_2000, 32'h0, 1'b0, lat, rd, np);
        total++; if (rd_cnt !== 1) begin bad++; $display("FAIL abort_rerefill_reads got=%0d want=1", rd_cnt); end
        total++; if (rd_addr !== 32'h0000_2000) begin bad++; $display("FAIL abort_rerefill_addr got=%h want=00002000", rd_addr); end
        total++; if (rd !== 32'hE0) begin bad++; $display("FAIL abort_rerefill_data got=%h want=000000e0", rd); end
        total++; if (lat !== 7) begin bad++; $display("FAIL abort_rerefill_latency got=%0d want=7", lat); end
        mem_setup(32'hF0, 32'hF1, 32'hF2, 32'hF3);
        run_req(32'h0000_5234, 32'h0, 1'b0, lat, rd, np);
        total++; if (wb_cnt !== 0) begin bad++; $display("FAIL post_rst_writebacks got=%0d want=0", wb_cnt); end
        total++; if (rd !== 32'hF1) begin bad++; $display("FAIL post_rst_data got=%h want=000000f1", rd); end
    endtask

    initial begin
        cpu_req = '0;
        mem_data = '0;
        rst = 1'b1;
        mem_setup(32'h0, 32'h0, 32'h0, 32'h0);
        test_reset();
        test_cold_read();
        test_hit();
        test_write_back();
        test_stall();
`ifdef CACHE_STATS_EN
        test_stats();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
